// File: rtl/fanin_checker.sv
// Receive-side checker for a half-adder fanout tree: snapshots N sum/carry pairs,
// compares one pair per cycle against x^y / x&y and reports through valid/ready.
module fanin_checker #(
  parameter int N    = 10,
  parameter int IDXW = 4,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            x,
  input  logic            y,
  input  logic [N-1:0]    s_bus,
  input  logic [N-1:0]    c_bus,
  output logic            busy,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [CNTW-1:0] err_count,
  output logic [IDXW-1:0] first_err,
  output logic            any_err,
  output logic [N-1:0]    err_mask
);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t          state, state_nx;
  logic [IDXW-1:0] idx;
  logic            x_snap, y_snap;
  logic [N-1:0]    s_snap, c_snap;
  logic            last;
  logic            mismatch;

  assign last     = (idx == IDXW'(N - 1));
  assign mismatch = (s_snap[idx] != (x_snap ^ y_snap)) |
                    (c_snap[idx] != (x_snap & y_snap));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: next-state takes a default first so no path through the case
  // leaves it unassigned and infers a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start)     state_nx = SCAN;
      SCAN:    if (last)      state_nx = REPORT;
      REPORT:  if (res_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign res_valid = (state == REPORT);
  assign any_err   = (err_count != '0);

  // NOTE: the snapshot is only read after a start has loaded it, so it carries
  // no reset and avoids a reset-enable mux on every data bit.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      x_snap <= x;
      y_snap <= y;
      s_snap <= s_bus;
      c_snap <= c_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      err_count <= '0;
      first_err <= '0;
      err_mask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= '0;
            err_count <= '0;
            first_err <= '0;
            err_mask  <= '0;
          end
        end
        SCAN: begin
          if (mismatch) begin
            err_mask[idx] <= 1'b1;
            err_count     <= err_count + CNTW'(1);
            // an empty count means this is the first failure of the run
            if (err_count == '0) first_err <= idx;
          end
          if (!last) idx <= idx + IDXW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fanin_checker.sv
// Scoreboard bench for fanin_checker: stimulus pushes model results into a queue,
// a negedge monitor pops and compares them whenever the DUT presents res_valid.
module tb_fanin_checker;

  localparam int N    = 10;
  localparam int IDXW = 4;
  localparam int CNTW = 4;

  typedef struct {
    logic [CNTW-1:0] cnt;
    logic [IDXW-1:0] first;
    logic [N-1:0]    mask;
    int              done_edge;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst, start, x, y, res_ready;
  logic [N-1:0]    s_bus, c_bus;
  logic            busy, res_valid, any_err;
  logic [CNTW-1:0] err_count;
  logic [IDXW-1:0] first_err;
  logic [N-1:0]    err_mask;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  exp_t exp_q[$];

  fanin_checker #(.N(N), .IDXW(IDXW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .s_bus(s_bus), .c_bus(c_bus), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .err_count(err_count), .first_err(first_err),
    .any_err(any_err), .err_mask(err_mask)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Expected result straight from the rule: a pair is bad if either bit differs
  // from the golden half-adder output; the first failure is the lowest bad bit.
  function automatic exp_t model(input logic xv, input logic yv,
                                 input logic [N-1:0] s, input logic [N-1:0] c,
                                 input int start_edge);
    exp_t e;
    e.mask  = (s ^ {N{xv ^ yv}}) | (c ^ {N{xv & yv}});
    e.cnt   = CNTW'($countones(e.mask));
    e.first = '0;
    for (int i = N - 1; i >= 0; i--) if (e.mask[i]) e.first = IDXW'(i);
    e.done_edge = start_edge + N;
    return e;
  endfunction

  // Monitor: pops on the rising of res_valid, then checks every REPORT cycle.
  exp_t cur;
  bit   seen = 1'b0;
  always @(negedge clk) begin
    if (rst || !res_valid) begin
      seen = 1'b0;
    end else begin
      if (!seen) begin
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
          cur.cnt = 'x; cur.first = 'x; cur.mask = 'x; cur.done_edge = cyc;
        end else begin
          cur = exp_q.pop_front();
          check("latency", cyc, cur.done_edge);
        end
      end
      check("err_count", err_count, cur.cnt);
      check("first_err", first_err, cur.first);
      check("err_mask", err_mask, cur.mask);
      check("any_err", any_err, cur.cnt != 0);
      check("busy_in_report", busy, 1'b1);
    end
  end

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_res_valid"}, res_valid, 1'b0);
    check({tag, "_err_count"}, err_count, '0);
    check({tag, "_first_err"}, first_err, '0);
    check({tag, "_any_err"}, any_err, 1'b0);
    check({tag, "_err_mask"}, err_mask, '0);
  endtask

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input logic xv, input logic yv,
                       input logic [N-1:0] s, input logic [N-1:0] c, input bit push);
    x = xv; y = yv; s_bus = s; c_bus = c; start = 1'b1;
    if (push) exp_q.push_back(model(xv, yv, s, c, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    check("busy_in_scan", busy, 1'b1);
  endtask

  task automatic wait_result();
    int k = 0;
    while (!res_valid && k < N + 4) begin
      @(negedge clk);
      k++;
    end
    if (!res_valid) check("res_valid_timeout", 32'd0, 32'd1);
  endtask

  // Full run: optional bus disturbance and stray starts, hold, then accept.
  task automatic run(input logic xv, input logic yv,
                     input logic [N-1:0] s, input logic [N-1:0] c,
                     input int hold, input bit disturb);
    issue(xv, yv, s, c, 1'b1);
    if (disturb) begin
      s_bus = {N{xv ^ yv}}; c_bus = {N{xv & yv}}; x = ~xv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_result();
    repeat (hold) @(negedge clk);
    if (disturb) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_valid_after_accept", res_valid, 1'b0);
    check("busy_after_accept", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x = 1'b0; y = 1'b0; res_ready = 1'b0;
    s_bus = '0; c_bus = '0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run(1'b1, 1'b0, 10'h3FF, 10'h000, 0, 1'b0);   // clean run
    run(1'b1, 1'b1, 10'h088, 10'h3FF, 2, 1'b1);   // two faults, bus changed mid-scan
    run(1'b0, 1'b0, 10'h3FF, 10'h3FF, 0, 1'b0);   // every pair wrong
    run(1'b0, 1'b1, 10'h2A1, 10'h004, 5, 1'b1);   // long hold, stray starts

    // Reset at scan index 4 discards the run.
    issue(1'b0, 1'b0, 10'h3FF, 10'h3FF, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("mid_reset");
    run(1'b1, 1'b1, 10'h200, 10'h3FE, 0, 1'b0);   // full result after reset

    // Start on the acceptance edge is ignored.
    issue(1'b0, 1'b0, 10'h001, 10'h000, 1'b1);
    wait_result();
    res_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    res_ready = 1'b0; start = 1'b0;
    check("start_on_accept_ignored", busy, 1'b0);
    @(negedge clk);
    check("still_idle", busy, 1'b0);

    // Back-to-back: start the cycle right after acceptance.
    issue(1'b1, 1'b1, 10'h3F0, 10'h3FF, 1'b1);
    wait_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    run(1'b1, 1'b1, 10'h3FF, 10'h3FF, 1, 1'b0);

    for (int r = 0; r < 10; r++) begin
      logic xv, yv;
      logic [N-1:0] s, c;
      xv = 1'($urandom); yv = 1'($urandom);
      if (r % 2 == 0) begin
        s = N'($urandom); c = N'($urandom);
      end else begin
        s = {N{xv ^ yv}} ^ N'($urandom & $urandom & $urandom);
        c = {N{xv & yv}} ^ N'($urandom & $urandom & $urandom);
      end
      run(xv, yv, s, c, int'($urandom_range(0, 3)), 1'($urandom));
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
